// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo slew controller.
package servo_pkg;

   typedef struct packed {
      logic [15:0] width_us;
      logic [7:0]  step_us;
   } servo_cmd_t;

   typedef enum logic {S_IDLE, S_MOVE} servo_slew_state_t;

   function automatic logic [15:0] clamp_us(
      input logic [15:0] w,
      input logic [15:0] lo,
      input logic [15:0] hi
   );
      if (w < lo) return lo;
      if (w > hi) return hi;
      return w;
   endfunction

endpackage

// File: rtl/servo_slew_ctrl_if.sv
// Command valid/ready bundle between the command source and the slew stage.
interface servo_slew_ctrl_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_width_us;
   logic [7:0]  cmd_step_us;

   modport master (
      output cmd_valid,
      output cmd_width_us,
      output cmd_step_us,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_width_us,
      input  cmd_step_us,
      output cmd_ready
   );

endinterface

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO; a push is accepted when full if a pop frees a slot.
module servo_cmd_fifo
   import servo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  servo_cmd_t din,
   input  logic       pop,
   output servo_cmd_t dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   servo_cmd_t       mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Slew-limited servo width stage with its own PWM frame timebase.
// Optional command FIFO enabled by defining SERVO_CMD_QUEUE_EN.
module servo_slew_ctrl
   import servo_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int FRAME_US        = 20_000,
   parameter int MIN_US          = 1_000,
   parameter int MAX_US          = 2_000,
   parameter int HOME_US         = 1_500,
   parameter int DEFAULT_STEP_US = 10
`ifdef SERVO_CMD_QUEUE_EN
   ,
   parameter int QUEUE_DEPTH     = 4
`endif
) (
   input  logic              clk,
   input  logic              rst,
   servo_slew_ctrl_if.slave  cmd,
   output logic [15:0]       width_us,
   output logic              frame_tick,
   output logic              busy,
   output logic              at_target
);

   localparam int TICKS_PER_US = CLK_HZ / 1_000_000;
   localparam int FRAME_TICKS  = FRAME_US * TICKS_PER_US;
   localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   logic [CW-1:0]      ctr_q, ctr_d;
   servo_slew_state_t  state_q, state_d;
   logic [15:0]        width_q, width_d;
   logic [15:0]        tgt_q, tgt_d;
   logic [7:0]         step_q, step_d;
   logic               busy_q, busy_d;
   logic               at_q, at_d;

   servo_cmd_t         in_cmd;
   logic               take;
   logic               q_busy;
   logic [15:0]        tgt_new;
   logic [7:0]         step_new;
   logic signed [16:0] diff;
   logic [16:0]        mag;

`ifdef SERVO_CMD_QUEUE_EN
   logic       q_full, q_empty, q_push;
   servo_cmd_t q_din, q_dout;

   assign q_din.width_us = cmd.cmd_width_us;
   assign q_din.step_us  = cmd.cmd_step_us;
   assign cmd.cmd_ready  = !q_full && !rst;
   assign q_push         = cmd.cmd_valid && cmd.cmd_ready;
   // Popping only from a registered IDLE keeps arrival and pop in separate cycles.
   assign take           = (state_q == S_IDLE) && !q_empty;
   assign in_cmd         = q_dout;
   assign q_busy         = !q_empty;

   servo_cmd_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .din   (q_din),
      .pop   (take),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );
`else
   assign cmd.cmd_ready   = (state_q == S_IDLE) && !rst;
   assign take            = cmd.cmd_valid && cmd.cmd_ready;
   assign in_cmd.width_us = cmd.cmd_width_us;
   assign in_cmd.step_us  = cmd.cmd_step_us;
   assign q_busy          = 1'b0;
`endif

   assign frame_tick = (ctr_q == CW'(FRAME_TICKS - 1));
   assign width_us   = width_q;
   assign busy       = busy_q || q_busy;
   assign at_target  = at_q;

   assign tgt_new  = clamp_us(in_cmd.width_us, 16'(MIN_US), 16'(MAX_US));
   assign step_new = (in_cmd.step_us == 8'd0) ? 8'(DEFAULT_STEP_US)
                                               : in_cmd.step_us;
   assign diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, width_q});
   assign mag      = diff[16] ? 17'(-diff) : 17'(diff);

   always_comb begin
      ctr_d   = frame_tick ? '0 : ctr_q + 1'b1;
      state_d = state_q;
      width_d = width_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      unique case (state_q)
         S_IDLE: begin
            if (take) begin
               tgt_d  = tgt_new;
               step_d = step_new;
               if (tgt_new != width_q) state_d = S_MOVE;
            end
         end
         S_MOVE: begin
            if (frame_tick) begin
               if (mag <= {9'd0, step_q}) begin
                  width_d = tgt_q;
                  state_d = S_IDLE;
               end else if (diff[16]) begin
                  width_d = width_q - {8'd0, step_q};
               end else begin
                  width_d = width_q + {8'd0, step_q};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_MOVE);
      at_d   = (state_d == S_IDLE) && (width_d == tgt_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q   <= '0;
         state_q <= S_IDLE;
         width_q <= 16'(HOME_US);
         tgt_q   <= 16'(HOME_US);
         step_q  <= 8'(DEFAULT_STEP_US);
         busy_q  <= 1'b0;
         at_q    <= 1'b1;
      end else begin
         ctr_q   <= ctr_d;
         state_q <= state_d;
         width_q <= width_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         at_q    <= at_d;
      end
   end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Scoreboard bench for servo_slew_ctrl with a 100-clock frame.
module tb_servo_slew_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] width_us;
   logic        frame_tick;
   logic        busy;
   logic        at_target;

   int n_tests = 0;
   int n_fail  = 0;
   int m_pos   = 1500;
   logic [15:0] exp_q [$];

   servo_slew_ctrl_if cmd_if ();

   servo_slew_ctrl #(
      .CLK_HZ   (1_000_000),
      .FRAME_US (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd_if.slave),
      .width_us   (width_us),
      .frame_tick (frame_tick),
      .busy       (busy),
      .at_target  (at_target)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference trajectory: one entry per frame in which width_us changes.
   function automatic void push_traj(input int w, input int s);
      int t;
      int st;
      t  = (w < 1000) ? 1000 : ((w > 2000) ? 2000 : w);
      st = (s == 0) ? 10 : s;
      while (m_pos != t) begin
         if (t - m_pos > st)      m_pos = m_pos + st;
         else if (m_pos - t > st) m_pos = m_pos - st;
         else                     m_pos = t;
         exp_q.push_back(16'(m_pos));
      end
   endfunction

   task automatic send_cmd(input int w, input int s);
      int n;
      n = 0;
      @(negedge clk);
      cmd_if.cmd_valid    = 1'b1;
      cmd_if.cmd_width_us = 16'(w);
      cmd_if.cmd_step_us  = 8'(s);
      while (!cmd_if.cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_if.cmd_ready);
      end
      push_traj(w, s);
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic run_frames(input string name);
      logic [15:0] exp;
      logic [15:0] prev;
      int n;
      prev = width_us;
      while (exp_q.size() > 0) begin
         n = 0;
         @(negedge clk);
         while (!frame_tick && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_tick_timeout: no frame_tick within 200 clks", name);
            exp_q.delete();
            break;
         end
         n_tests++;
         if (width_us !== prev) begin
            n_fail++;
            $display("FAIL %s_hold: width_us=%0d required %0d", name, width_us, prev);
         end
         @(negedge clk);
         exp = exp_q.pop_front();
         n_tests++;
         if (width_us !== exp) begin
            n_fail++;
            $display("FAIL %s_step: width_us=%0d required %0d", name, width_us, exp);
         end
         prev = exp;
      end
      n_tests++;
      if (busy !== 1'b0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done: busy=%0b at_target=%0b required 0 1", name, busy, at_target);
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (cmd_if.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: cmd_ready=%0b required 0", cmd_if.cmd_ready);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (width_us !== 16'd1500 || at_target !== 1'b1 || busy !== 1'b0 ||
          cmd_if.cmd_ready !== 1'b1 || frame_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_state: w=%0d at=%0b busy=%0b rdy=%0b ft=%0b required 1500 1 0 1 0",
                  width_us, at_target, busy, cmd_if.cmd_ready, frame_tick);
      end
      n = 0;
      while (!frame_tick && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      @(negedge clk);
      while (!frame_tick && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n + 1 != 100) begin
         n_fail++;
         $display("FAIL frame_period: period=%0d required 100", n + 1);
      end
      m_pos = 1500;
   endtask

   task automatic test_ramp_up();
      send_cmd(1530, 10);
      run_frames("ramp");
   endtask

   task automatic test_clamp_default();
      send_cmd(2500, 0);
      run_frames("clamp_hi");
   endtask

   task automatic test_partial_step();
      send_cmd(1500, 250);
      run_frames("big_step");
      send_cmd(1475, 10);
      run_frames("partial");
      send_cmd(1500, 0);
      run_frames("return");
   endtask

   task automatic test_accept_on_tick();
      int n;
      n = 0;
      @(negedge clk);
      while (!frame_tick && n < 200) begin
         @(negedge clk);
         n++;
      end
      cmd_if.cmd_valid    = 1'b1;
      cmd_if.cmd_width_us = 16'd1520;
      cmd_if.cmd_step_us  = 8'd20;
      n_tests++;
      if (cmd_if.cmd_ready !== 1'b1 || frame_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_accept_setup: rdy=%0b ft=%0b required 1 1",
                  cmd_if.cmd_ready, frame_tick);
      end
      push_traj(1520, 20);
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (width_us !== 16'd1500) begin
         n_fail++;
         $display("FAIL tick_accept_hold: width_us=%0d required 1500", width_us);
      end
      run_frames("tick_accept");
   endtask

   task automatic test_same_and_low();
      send_cmd(1520, 5);
      repeat (2) @(negedge clk);
      n_tests++;
      if (width_us !== 16'd1520 || busy !== 1'b0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL same_target: w=%0d busy=%0b at=%0b required 1520 0 1",
                  width_us, busy, at_target);
      end
      send_cmd(500, 255);
      run_frames("clamp_lo");
   endtask

   task automatic test_reset_mid_move();
      send_cmd(2000, 10);
`ifdef SERVO_CMD_QUEUE_EN
      send_cmd(1000, 10);
      send_cmd(1900, 20);
`endif
      exp_q.delete();
      repeat (250) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (width_us !== 16'd1500 || busy !== 1'b0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: w=%0d busy=%0b at=%0b required 1500 0 1",
                  width_us, busy, at_target);
      end
      repeat (300) @(negedge clk);
      n_tests++;
      if (width_us !== 16'd1500 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_after: w=%0d busy=%0b required 1500 0", width_us, busy);
      end
      m_pos = 1500;
   endtask

`ifdef SERVO_CMD_QUEUE_EN
   task automatic test_queue();
      int ws [4] = '{1700, 1650, 2000, 1800};
      int ss [4] = '{100, 0, 255, 200};
      send_cmd(1600, 50);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cmd_if.cmd_valid    = 1'b1;
         cmd_if.cmd_width_us = 16'(ws[i]);
         cmd_if.cmd_step_us  = 8'(ss[i]);
         n_tests++;
         if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL q_push%0d: cmd_ready=%0b required 1", i, cmd_if.cmd_ready);
         end
         push_traj(ws[i], ss[i]);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      cmd_if.cmd_width_us = 16'd1234;
      n_tests++;
      if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL q_full: rdy=%0b busy=%0b required 0 1", cmd_if.cmd_ready, busy);
      end
      cmd_if.cmd_valid = 1'b0;
      run_frames("queue");
   endtask
`endif

   initial begin
      cmd_if.cmd_valid    = 1'b0;
      cmd_if.cmd_width_us = 16'd0;
      cmd_if.cmd_step_us  = 8'd0;
      test_reset();
      test_ramp_up();
      test_clamp_default();
      test_partial_step();
      test_accept_on_tick();
      test_same_and_low();
      test_reset_mid_move();
`ifdef SERVO_CMD_QUEUE_EN
      test_queue();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
